md_unit_e: RTL
==============

# md_unit_e

Execute-stage iterative multiply/divide unit for the RV32M extension. It consumes the operands and `funct3E` that the ID/EX pipeline register delivers to the execute stage, after forwarding muxes. It holds the pipeline via a stall request while an operation is in flight. It presents a 32-bit result alongside the ALU result for the EX/MEM register to capture.

## Interface
Parameters:
- `DATA_WIDTH`, 32, operand and result width.
- `FUNCT3_WIDTH`, 3, width of the M-op selector.
- `CNT_WIDTH`, 5, iteration counter width (log2 `DATA_WIDTH`).

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock, all state updates on the rising edge.
- `RST`  in  1  synchronous active-high reset.
- `MdValidE`  in  1  the instruction in E is an M-extension op; held high while stalled.
- `funct3E`  in  `FUNCT3_WIDTH`  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`  in  `DATA_WIDTH`  forwarded rs1 value.
- `SrcBE`  in  `DATA_WIDTH`  forwarded rs2 value.
- `FlushE`  in  1  kills any in-flight op.
- `MdStallE`  out  1  stall request to the hazard unit: freeze F, D and E.
- `MdDoneE`  out  1  one-cycle pulse; `MdResultE` is valid.
- `MdResultE`  out  `DATA_WIDTH`  result; holds its last value until the next `MdDoneE`.

## Operation
- **States:** IDLE, MUL, DIV, DONE.
- **Issue:** in IDLE with `MdValidE`=1 and `FlushE`=0:
  - latch operand magnitudes, sign flags and `funct3E`;
  - load counter with 31;
  - go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- **Early-out (divide only):** if the divisor is 0 or it is signed overflow (0x80000000 / 0xFFFFFFFF with DIV/REM), go straight to DONE.
- **MUL:** radix-2 shift-add on unsigned magnitudes into a 64-bit product; one bit per cycle; counter decrements; at 0 go to DONE.
- **DIV:** radix-2 restoring divide on magnitudes; one quotient bit per cycle; at counter 0 go to DONE.
- **Signedness:**
  - MUL and MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU and DIVU/REMU: unsigned.
  - Negate the product if the operand signs differ.
  - Quotient is negative if the signs differ; remainder takes the dividend's sign.
- **Result select:** MUL gives product[31:0]; MULH* give product[63:32].
- **Special cases:**
  - Divide by 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow: DIV returns 0x80000000; REM returns 0.
- **DONE:** drive `MdResultE` and assert `MdDoneE` for one cycle; next state IDLE.
- **MdStallE** = (state is MUL or DIV) OR (state is IDLE AND `MdValidE` AND NOT `FlushE`). It is 0 in DONE, so the pipeline advances that same cycle.
- **Flush:** `FlushE`=1 in any state forces IDLE next cycle. No `MdDoneE` is issued and `MdResultE` is unchanged. Flush beats issue.
- **Reset:** state IDLE, counter 0, `MdDoneE` 0, `MdResultE` 0. `MdStallE` is forced 0 while `RST` is high.

## Timing
- Issue at cycle t. The iterative op occupies cycles t+1..t+32, DONE is at t+33, and stall is asserted for t..t+32 (33 cycles).
- Early-out divide: DONE at t+1, stall is asserted for cycle t only.
- Back-to-back M-ops: the second op is seen in IDLE at t+34 and issues then; no bubble beyond that.
- `MdResultE` and `MdDoneE` are registered: no combinational path from `SrcAE`/`SrcBE` to the outputs.
- `FlushE` mid-operation at cycle k: IDLE at k+1; a new `MdValidE` is accepted from k+1.

## Configuration
- `MD_FAST_MUL_EN`:
  - **Defined:** MUL-class ops compute the full 64-bit signed/unsigned product combinationally from the latched operands in the first MUL cycle and go to DONE at t+2 (stall for 2 cycles).
  - **Undefined:** the 32-cycle shift-add path is used.
- Divide behaviour is identical either way.

## Structure
- Shared package `md_pkg`:
  - `md_op_t` enum for the eight funct3 codes;
  - `md_state_t` enum (IDLE, MUL, DIV, DONE);
  - constants `MD_DIV_ZERO_Q` (0xFFFFFFFF) and `MD_INT_MIN` (0x80000000).
- One sub-module, `md_div_core`: restoring-divide datapath (remainder/quotient registers, one-step subtract/shift), driven by the top-level FSM and counter.

## Test plan
- MUL 7 × 0xFFFFFFFD -> 0xFFFFFFEB, with `MdDoneE` at t+33 and `MdStallE` high for 33 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
- DIV 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, both with `MdDoneE` at t+1; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0.
- `FlushE` pulsed at t+10 of a DIV -> IDLE at t+11, no `MdDoneE`, `MdResultE` unchanged. A following MUL issued at t+11 completes correctly at t+44.
- `RST` asserted mid-MUL -> next cycle all outputs 0 and state IDLE. With `MD_FAST_MUL_EN` defined, MUL 3 × 4 -> 12 at t+2.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M execute-stage multiply/divide unit.
package md_pkg;

    localparam int unsigned MD_XLEN = 32;

    // funct3 encodings of the M-extension ops
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Per-operation context captured at issue
    typedef struct packed {
        md_op_t op;
        logic   sign_a;
        logic   sign_b;
    } md_ctx_t;

    localparam logic [MD_XLEN-1:0] MD_DIV_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [MD_XLEN-1:0] MD_INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/md_div_core.sv
// Restoring-divide datapath: one quotient bit per step on unsigned magnitudes.
// Sequencing (load/step/termination) is owned by the parent FSM and counter.
module md_div_core
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MD_XLEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quo_c,
    output logic [DATA_WIDTH-1:0] rem_c
);

    logic [DATA_WIDTH-1:0] rem_q;
    logic [DATA_WIDTH-1:0] quo_q;
    logic [DATA_WIDTH-1:0] dvs_q;
    logic [DATA_WIDTH:0]   trial_c;
    logic [DATA_WIDTH:0]   diff_c;

    // One trial-subtract step; a borrow out of the top bit means restore
    always_comb begin
        trial_c = {rem_q, quo_q[DATA_WIDTH-1]};
        diff_c  = trial_c - {1'b0, dvs_q};
        if (!diff_c[DATA_WIDTH]) begin
            rem_c = diff_c[DATA_WIDTH-1:0];
            quo_c = {quo_q[DATA_WIDTH-2:0], 1'b1};
        end else begin
            rem_c = trial_c[DATA_WIDTH-1:0];
            quo_c = {quo_q[DATA_WIDTH-2:0], 1'b0};
        end
    end

    // Partial remainder / quotient / divisor registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
        end else if (step) begin
            rem_q <= rem_c;
            quo_q <= quo_c;
        end
    end

endmodule

// File: rtl/md_unit_e.sv
// Execute-stage iterative RV32M multiply/divide unit with pipeline stall request.
// Optional macro MD_FAST_MUL_EN: single-cycle combinational multiply instead of
// the 32-cycle shift-add; divide is unaffected.
module md_unit_e
    import md_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned FUNCT3_WIDTH = 3,
    parameter int unsigned CNT_WIDTH    = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    MdValidE,
    input  logic [FUNCT3_WIDTH-1:0] funct3E,
    input  logic [DATA_WIDTH-1:0]   SrcAE,
    input  logic [DATA_WIDTH-1:0]   SrcBE,
    input  logic                    FlushE,
    output logic                    MdStallE,
    output logic                    MdDoneE,
    output logic [DATA_WIDTH-1:0]   MdResultE
);

    localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

    md_state_t             state;
    md_state_t             state_next;
    logic [CNT_WIDTH-1:0]  cnt;
    md_ctx_t               ctx;
    logic [DATA_WIDTH-1:0] a_mag;

    logic                  issue_c;
    logic                  in_is_div;
    logic                  in_sign_a;
    logic                  in_sign_b;
    logic [DATA_WIDTH-1:0] in_a_mag;
    logic [DATA_WIDTH-1:0] in_b_mag;
    logic                  div_zero_c;
    logic                  div_ovf_c;
    logic                  early_c;
    logic [DATA_WIDTH-1:0] early_result_c;

    logic [PROD_WIDTH-1:0] prod_fin_c;
    logic [PROD_WIDTH-1:0] prod_signed_c;
    logic [DATA_WIDTH-1:0] mul_result_c;
    logic [DATA_WIDTH-1:0] quo_c;
    logic [DATA_WIDTH-1:0] rem_c;
    logic [DATA_WIDTH-1:0] div_result_c;

    // Issue decode: signedness, magnitudes and divide early-out from the E-stage operands
    always_comb begin
        issue_c    = (state == IDLE) && MdValidE && !FlushE;
        in_is_div  = funct3E[2];
        if (in_is_div) begin
            in_sign_a = !funct3E[0] && SrcAE[DATA_WIDTH-1];
            in_sign_b = !funct3E[0] && SrcBE[DATA_WIDTH-1];
        end else begin
            in_sign_a = (funct3E[1:0] != 2'b11) && SrcAE[DATA_WIDTH-1];
            in_sign_b = !funct3E[1] && SrcBE[DATA_WIDTH-1];
        end
        in_a_mag   = in_sign_a ? -SrcAE : SrcAE;
        in_b_mag   = in_sign_b ? -SrcBE : SrcBE;
        div_zero_c = (SrcBE == '0);
        div_ovf_c  = !funct3E[0] && (SrcAE == MD_INT_MIN) && (SrcBE == '1);
        early_c    = in_is_div && (div_zero_c || div_ovf_c);
        if (funct3E[1]) begin
            early_result_c = div_zero_c ? SrcAE : '0;
        end else begin
            early_result_c = div_zero_c ? MD_DIV_ZERO_Q : MD_INT_MIN;
        end
    end

`ifdef MD_FAST_MUL_EN
    logic [DATA_WIDTH-1:0] b_mag;

    // Full-width product of the latched magnitudes in a single cycle
    always_comb begin
        prod_fin_c = PROD_WIDTH'(a_mag) * PROD_WIDTH'(b_mag);
    end
`else
    logic [PROD_WIDTH-1:0] prod;
    logic [DATA_WIDTH:0]   psum_c;

    // Shift-add step: multiplier sits in the low half and is consumed LSB first
    always_comb begin
        psum_c     = {1'b0, prod[PROD_WIDTH-1:DATA_WIDTH]}
                   + (prod[0] ? {1'b0, a_mag} : '0);
        prod_fin_c = {psum_c, prod[DATA_WIDTH-1:1]};
    end
`endif

    // Sign fix-up and result selection for both datapaths
    always_comb begin
        prod_signed_c = (ctx.sign_a ^ ctx.sign_b) ? -prod_fin_c : prod_fin_c;
        mul_result_c  = (ctx.op == OP_MUL) ? prod_signed_c[DATA_WIDTH-1:0]
                                           : prod_signed_c[PROD_WIDTH-1:DATA_WIDTH];
        if (ctx.op[1]) begin
            div_result_c = ctx.sign_a ? -rem_c : rem_c;
        end else begin
            div_result_c = (ctx.sign_a ^ ctx.sign_b) ? -quo_c : quo_c;
        end
    end

    md_div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_core (
        .clk      (CLK),
        .rst      (RST),
        .load     (issue_c && in_is_div),
        .step     ((state == DIV) && !FlushE),
        .dividend (in_a_mag),
        .divisor  (in_b_mag),
        .quo_c    (quo_c),
        .rem_c    (rem_c)
    );

    // Next-state and stall request; flush wins over everything
    always_comb begin
        state_next = state;
        MdStallE   = 1'b0;
        case (state)
            IDLE: begin
                if (issue_c) begin
                    MdStallE = 1'b1;
                    if (in_is_div) begin
                        state_next = early_c ? DONE : DIV;
                    end else begin
                        state_next = MUL;
                    end
                end
            end
            MUL: begin
                MdStallE = 1'b1;
`ifdef MD_FAST_MUL_EN
                state_next = DONE;
`else
                if (cnt == '0) begin
                    state_next = DONE;
                end
`endif
            end
            DIV: begin
                MdStallE = 1'b1;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (FlushE) begin
            state_next = IDLE;
        end
        if (RST) begin
            MdStallE = 1'b0;
        end
    end

    // State, operand capture, iteration counter and registered result/done
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ctx       <= '0;
            a_mag     <= '0;
            MdDoneE   <= 1'b0;
            MdResultE <= '0;
`ifdef MD_FAST_MUL_EN
            b_mag     <= '0;
`else
            prod      <= '0;
`endif
        end else begin
            state   <= state_next;
            MdDoneE <= 1'b0;
            if (issue_c) begin
                ctx.op     <= md_op_t'(funct3E);
                ctx.sign_a <= in_sign_a;
                ctx.sign_b <= in_sign_b;
                a_mag      <= in_a_mag;
                cnt        <= CNT_WIDTH'(DATA_WIDTH - 1);
`ifdef MD_FAST_MUL_EN
                b_mag      <= in_b_mag;
`else
                prod       <= {{DATA_WIDTH{1'b0}}, in_b_mag};
`endif
                if (early_c) begin
                    MdResultE <= early_result_c;
                    MdDoneE   <= 1'b1;
                end
            end else if (((state == MUL) || (state == DIV)) && !FlushE) begin
                cnt <= cnt - CNT_WIDTH'(1);
`ifndef MD_FAST_MUL_EN
                prod <= prod_fin_c;
`endif
                if (state_next == DONE) begin
                    MdResultE <= (state == MUL) ? mul_result_c : div_result_c;
                    MdDoneE   <= 1'b1;
                end
            end
        end
    end

endmodule
